lfc_ram_arbiter: RTL and testbench
==================================

Name: lfc_ram_arbiter

Overview:
- Shares one backing-RAM port among the NUM_BANKS per-bank RAM request channels of the lockup-free cache.
- Arbitration is round-robin, with one outstanding transaction at a time.
- The granted bank's request is captured into registers and driven to RAM until RAM signals completion; read data and a one-cycle complete pulse are then returned to that bank only.
- Sits between the cache bank RAM channels (ram_mem_* vectors) and the single memory-side port.

Parameters:
- NUM_BANKS, 4, number of bank request channels; must be at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width for load and store.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ram_mem_REN  input  NUM_BANKS  per-bank read request; level, held until that bank's complete pulse.
- ram_mem_WEN  input  NUM_BANKS  per-bank write request; level, held until that bank's complete pulse.
- ram_mem_addr  input  NUM_BANKS x ADDR_W  per-bank address.
- ram_mem_store  input  NUM_BANKS x DATA_W  per-bank store data.
- ram_mem_data  output  NUM_BANKS x DATA_W  per-bank load data; valid for bank g only while ram_mem_complete[g] is high.
- ram_mem_complete  output  NUM_BANKS  per-bank one-cycle completion pulse.
- mem_REN  output  1  read strobe to RAM.
- mem_WEN  output  1  write strobe to RAM.
- mem_addr  output  ADDR_W  address to RAM.
- mem_store  output  DATA_W  store data to RAM.
- mem_load  input  DATA_W  read data from RAM; valid when mem_complete is high.
- mem_complete  input  1  RAM completion, sampled only in BUSY.
- grant  output  NUM_BANKS  one-hot granted bank; zero when not BUSY or RESP.
- busy  output  1  high in BUSY and RESP.

Behaviour:
- Reset values (asynchronous, rst high):
  - state = IDLE; rr_ptr = 0.
  - All outputs are 0: mem_REN, mem_WEN, mem_addr, mem_store, ram_mem_data, ram_mem_complete, grant, busy.
- Request definition: req[i] = ram_mem_REN[i] | ram_mem_WEN[i].
- IDLE:
  - If any req is high, select the first requesting bank searching upward from rr_ptr, modulo NUM_BANKS.
  - On the clock edge, latch the following and go to BUSY:
    - g = the selected bank;
    - op_write = ram_mem_WEN[g];
    - addr_q = ram_mem_addr[g];
    - store_q = ram_mem_store[g].
  - If no req is high, stay in IDLE.
- Write precedence: if a bank asserts both REN and WEN, the transaction is a write.
- BUSY:
  - mem_REN = !op_write and mem_WEN = op_write, both driven from registers.
  - mem_addr = addr_q and mem_store = store_q.
  - Strobes stay high every BUSY cycle until mem_complete is sampled high.
  - On mem_complete: latch load_q = mem_load (reads only; writes return 0) and go to RESP.
- RESP (exactly one cycle):
  - ram_mem_complete[g] = 1 and ram_mem_data[g] = load_q; all other banks' outputs are 0.
  - mem_REN = 0 and mem_WEN = 0.
  - rr_ptr <= (g + 1) mod NUM_BANKS.
  - Next state is IDLE.
- Latency:
  - A request seen in IDLE reaches the RAM strobes 1 cycle later.
  - Complete reaches the bank 1 cycle after mem_complete.
  - Minimum turnaround is 3 cycles per transaction (IDLE, BUSY, RESP) when mem_complete arrives in the first BUSY cycle.
  - There is no back-to-back issue; IDLE always separates transactions.
- Bank protocol:
  - A bank deasserts its request on the edge following its complete pulse, so it is already low in the next IDLE.
  - A bank still requesting in IDLE after its complete is treated as a new request.
- Changes after capture: changes on the granted bank's inputs during BUSY or RESP are ignored.
- Request withdrawal:
  - A non-granted bank that drops its request before being granted is simply skipped.
  - A granted bank that drops its request mid-transaction still receives its complete pulse.
- Fairness: a continuously requesting bank waits at most NUM_BANKS-1 transactions.
- mem_complete outside BUSY is ignored.
- Reset mid-transaction:
  - All outputs clear immediately and the in-flight transaction is abandoned.
  - No complete pulse is issued for it.
- Pointer wrap: rr_ptr wraps from NUM_BANKS-1 to 0.

Test Plan:
- Single read: bank 2 REN, addr 0x100, RAM completes 2 cycles after strobe with 0xDEADBEEF -> mem_REN high for 2 cycles with mem_addr 0x100; ram_mem_complete = 4'b0100 for 1 cycle with ram_mem_data[2] = 0xDEADBEEF; rr_ptr = 3.
- Single write: bank 0 WEN, addr 0x40, store 0x12345678 -> mem_WEN high with mem_store 0x12345678; complete pulse on bank 0; ram_mem_data[0] = 0.
- Contention: all 4 banks request from reset, each re-requests immediately after its complete -> grant order 0,1,2,3,0; no bank waits more than 3 transactions.
- Simultaneous REN+WEN on bank 1 -> write issued; mem_REN never high.
- Input change and withdrawal:
  - Bank 3 granted; during BUSY its addr changes 0x200 to 0x300 -> mem_addr holds 0x200.
  - Bank 1 drops its request while waiting -> bank 1 skipped, no complete on bank 1.
- Reset in BUSY: rst pulsed while mem_REN high -> all outputs 0 in the same cycle; state IDLE; rr_ptr = 0; stray mem_complete afterwards produces no pulse.

Source files
------------

// File: rtl/lfc_ram_arbiter.sv
// Round-robin arbiter sharing one backing-RAM port among the per-bank RAM
// request channels of the lockup-free cache. One transaction in flight at a
// time: the winner's request is captured, driven to RAM until mem_complete,
// then a one-cycle complete pulse (with load data) is returned to that bank.
module lfc_ram_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BANKS-1:0]                ram_mem_REN,
  input  logic [NUM_BANKS-1:0]                ram_mem_WEN,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]    ram_mem_addr,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]    ram_mem_store,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]    ram_mem_data,
  output logic [NUM_BANKS-1:0]                ram_mem_complete,
  output logic                                mem_REN,
  output logic                                mem_WEN,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_store,
  input  logic [DATA_W-1:0]                   mem_load,
  input  logic                                mem_complete,
  output logic [NUM_BANKS-1:0]                grant,
  output logic                                busy
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                             r_state;
  logic [IDX_W-1:0]                   r_rr_ptr;
  logic [IDX_W-1:0]                   r_gnt_idx;
  logic                               r_op_write;
  logic [ADDR_W-1:0]                  r_addr;
  logic [DATA_W-1:0]                  r_store;
  logic                               r_ren;
  logic                               r_wen;
  logic [NUM_BANKS-1:0][DATA_W-1:0]   r_data;
  logic [NUM_BANKS-1:0]               r_complete;
  logic [NUM_BANKS-1:0]               r_grant;
  logic                               r_busy;

  logic [NUM_BANKS-1:0]               w_req;
  logic                               w_found;
  logic [IDX_W-1:0]                   w_sel;
  logic [NUM_BANKS-1:0]               w_sel_onehot;
  logic [IDX_W-1:0]                   w_ptr_next;

  assign w_req = ram_mem_REN | ram_mem_WEN;

  // Pick the first requesting bank at or above rr_ptr, wrapping around.
  always_comb begin : sel_blk
    int unsigned idx;
    w_found      = 1'b0;
    w_sel        = '0;
    w_sel_onehot = '0;
    idx          = 0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_BANKS;
      if (!w_found && w_req[IDX_W'(idx)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(idx);
      end
    end
    if (w_found) w_sel_onehot[w_sel] = 1'b1;
  end

  assign w_ptr_next = (r_gnt_idx == IDX_W'(NUM_BANKS - 1)) ? '0 : r_gnt_idx + 1'b1;

  // Transaction FSM; every output is a register so nothing glitches toward RAM or the banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gnt_idx  <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_store    <= '0;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_data     <= '0;
      r_complete <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_complete <= '0;
          r_data     <= '0;
          if (w_found) begin
            // Write wins when a bank raises both REN and WEN.
            r_gnt_idx  <= w_sel;
            r_op_write <= ram_mem_WEN[w_sel];
            r_ren      <= ~ram_mem_WEN[w_sel];
            r_wen      <= ram_mem_WEN[w_sel];
            r_addr     <= ram_mem_addr[w_sel];
            r_store    <= ram_mem_store[w_sel];
            r_grant    <= w_sel_onehot;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_complete) begin
            r_ren                 <= 1'b0;
            r_wen                 <= 1'b0;
            r_complete[r_gnt_idx] <= 1'b1;
            r_data[r_gnt_idx]     <= r_op_write ? '0 : mem_load;
            r_state               <= S_RESP;
          end
        end
        S_RESP: begin
          r_complete <= '0;
          r_data     <= '0;
          r_grant    <= '0;
          r_busy     <= 1'b0;
          r_rr_ptr   <= w_ptr_next;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_REN          = r_ren;
  assign mem_WEN          = r_wen;
  assign mem_addr         = r_addr;
  assign mem_store        = r_store;
  assign ram_mem_data     = r_data;
  assign ram_mem_complete = r_complete;
  assign grant            = r_grant;
  assign busy             = r_busy;

endmodule

// File: tb/tb_lfc_ram_arbiter.sv
// Directed self-checking bench for lfc_ram_arbiter (4 banks, 32-bit addr/data).
module tb_lfc_ram_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NB-1:0]          ren, wen;
  logic [NB-1:0][AW-1:0]  addr;
  logic [NB-1:0][DW-1:0]  store;
  logic [NB-1:0][DW-1:0]  rdata;
  logic [NB-1:0]          cpl;
  logic                   mem_REN, mem_WEN;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_store;
  logic [DW-1:0]          mem_load;
  logic                   mem_complete;
  logic [NB-1:0]          grant;
  logic                   busy;

  int vectors = 0;
  int errors  = 0;

  lfc_ram_arbiter #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .ram_mem_REN      (ren),
    .ram_mem_WEN      (wen),
    .ram_mem_addr     (addr),
    .ram_mem_store    (store),
    .ram_mem_data     (rdata),
    .ram_mem_complete (cpl),
    .mem_REN          (mem_REN),
    .mem_WEN          (mem_WEN),
    .mem_addr         (mem_addr),
    .mem_store        (mem_store),
    .mem_load         (mem_load),
    .mem_complete     (mem_complete),
    .grant            (grant),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [NB*DW+NB+2+AW+DW+NB:0] all_out;
    repeat (2) tick;
    all_out = {rdata, cpl, mem_REN, mem_WEN, mem_addr, mem_store, grant, busy};
    vectors++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    vectors++;
    if (dut.r_rr_ptr !== 2'd0) begin
      errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.r_rr_ptr);
    end
    rst = 1'b0;
    // mem_complete is already high here; with no request it must be ignored.
    repeat (2) tick;
    vectors++;
    if ({cpl, busy, mem_REN, mem_WEN} !== '0) begin
      errors++; $display("FAIL idle_stray_complete: got %b want 0", {cpl, busy, mem_REN, mem_WEN});
    end
    mem_complete = 1'b0;
  endtask

  task automatic test_single_read;
    logic [NB-1:0][DW-1:0] expd;
    ren[2] = 1'b1; addr[2] = 32'h100;
    tick;
    vectors++;
    if ({mem_REN, mem_WEN, mem_addr, grant, busy} !== {1'b1, 1'b0, 32'h100, 4'b0100, 1'b1}) begin
      errors++; $display("FAIL read_busy1: got ren=%b wen=%b addr=%h grant=%b busy=%b want 1 0 100 0100 1",
                         mem_REN, mem_WEN, mem_addr, grant, busy);
    end
    tick;
    vectors++;
    if ({mem_REN, mem_addr, cpl} !== {1'b1, 32'h100, 4'b0000}) begin
      errors++; $display("FAIL read_busy2: got ren=%b addr=%h cpl=%b want 1 100 0000", mem_REN, mem_addr, cpl);
    end
    mem_complete = 1'b1; mem_load = 32'hDEADBEEF;
    tick;
    expd = '0; expd[2] = 32'hDEADBEEF;
    vectors++;
    if ({mem_REN, cpl, rdata} !== {1'b0, 4'b0100, expd}) begin
      errors++; $display("FAIL read_resp: got ren=%b cpl=%b data=%h want 0 0100 %h", mem_REN, cpl, rdata, expd);
    end
    ren[2] = 1'b0; mem_complete = 1'b0; mem_load = '0;
    tick;
    vectors++;
    if ({cpl, busy, grant, rdata} !== '0) begin
      errors++; $display("FAIL read_idle: got cpl=%b busy=%b grant=%b want 0", cpl, busy, grant);
    end
    vectors++;
    if (dut.r_rr_ptr !== 2'd3) begin
      errors++; $display("FAIL read_rr_ptr: got %0d want 3", dut.r_rr_ptr);
    end
  endtask

  task automatic test_single_write;
    wen[0] = 1'b1; addr[0] = 32'h40; store[0] = 32'h12345678;
    tick;
    vectors++;
    if ({mem_REN, mem_WEN, mem_addr, mem_store, grant} !== {1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0001}) begin
      errors++; $display("FAIL write_busy: got ren=%b wen=%b addr=%h store=%h grant=%b want 0 1 40 12345678 0001",
                         mem_REN, mem_WEN, mem_addr, mem_store, grant);
    end
    mem_complete = 1'b1; mem_load = 32'hCAFEF00D;
    tick;
    vectors++;
    if ({mem_WEN, cpl, rdata} !== {1'b0, 4'b0001, {(NB*DW){1'b0}}}) begin
      errors++; $display("FAIL write_resp: got wen=%b cpl=%b data=%h want 0 0001 0", mem_WEN, cpl, rdata);
    end
    wen[0] = 1'b0; mem_complete = 1'b0;
    tick;
    vectors++;
    if (dut.r_rr_ptr !== 2'd1) begin
      errors++; $display("FAIL write_rr_ptr: got %0d want 1", dut.r_rr_ptr);
    end
  endtask

  task automatic test_contention;
    int unsigned exp;
    logic [NB-1:0]         eg;
    logic [NB-1:0][DW-1:0] expd;
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < NB; i++) addr[i] = 32'h1000 + 32'(i);
    ren = 4'hF; mem_complete = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = k % NB;
      eg  = 4'b0001 << exp;
      mem_load = 32'h5A5A0000 + 32'(k);
      tick;
      vectors++;
      if ({grant, mem_addr} !== {eg, 32'h1000 + exp}) begin
        errors++; $display("FAIL contention_grant[%0d]: got grant=%b addr=%h want %b %h",
                           k, grant, mem_addr, eg, 32'h1000 + exp);
      end
      tick;
      expd = '0; expd[exp] = 32'h5A5A0000 + 32'(k);
      vectors++;
      if ({cpl, rdata} !== {eg, expd}) begin
        errors++; $display("FAIL contention_resp[%0d]: got cpl=%b data=%h want %b %h", k, cpl, rdata, eg, expd);
      end
      tick;
    end
    ren = '0; mem_complete = 1'b0;
    tick;
  endtask

  task automatic test_ren_wen;
    ren[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h80; store[1] = 32'hA5A5A5A5;
    tick;
    vectors++;
    if ({mem_REN, mem_WEN, mem_store, grant} !== {1'b0, 1'b1, 32'hA5A5A5A5, 4'b0010}) begin
      errors++; $display("FAIL renwen_busy: got ren=%b wen=%b store=%h grant=%b want 0 1 a5a5a5a5 0010",
                         mem_REN, mem_WEN, mem_store, grant);
    end
    mem_complete = 1'b1; mem_load = 32'hFFFFFFFF;
    tick;
    vectors++;
    if ({mem_REN, cpl, rdata} !== {1'b0, 4'b0010, {(NB*DW){1'b0}}}) begin
      errors++; $display("FAIL renwen_resp: got ren=%b cpl=%b data=%h want 0 0010 0", mem_REN, cpl, rdata);
    end
    ren[1] = 1'b0; wen[1] = 1'b0; mem_complete = 1'b0;
    tick;
  endtask

  task automatic test_change_withdraw;
    logic [NB-1:0][DW-1:0] expd;
    // rr_ptr is 2 here, so bank 3 beats the waiting bank 1.
    ren[3] = 1'b1; addr[3] = 32'h200;
    ren[1] = 1'b1; addr[1] = 32'h111;
    tick;
    vectors++;
    if ({grant, mem_addr} !== {4'b1000, 32'h200}) begin
      errors++; $display("FAIL change_grant: got grant=%b addr=%h want 1000 200", grant, mem_addr);
    end
    addr[3] = 32'h300; ren[3] = 1'b0;
    tick;
    vectors++;
    if ({mem_REN, mem_addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL change_addr_hold: got ren=%b addr=%h want 1 200", mem_REN, mem_addr);
    end
    ren[1] = 1'b0; mem_complete = 1'b1; mem_load = 32'h33;
    tick;
    expd = '0; expd[3] = 32'h33;
    vectors++;
    if ({cpl, rdata} !== {4'b1000, expd}) begin
      errors++; $display("FAIL withdraw_resp: got cpl=%b data=%h want 1000 %h", cpl, rdata, expd);
    end
    mem_complete = 1'b0;
    repeat (2) tick;
    vectors++;
    if ({cpl, grant, busy} !== '0) begin
      errors++; $display("FAIL withdraw_skip: got cpl=%b grant=%b busy=%b want 0", cpl, grant, busy);
    end
  endtask

  task automatic test_reset_busy;
    logic [NB*DW+NB+2+AW+DW+NB:0] all_out;
    ren[1] = 1'b1; mem_complete = 1'b1; mem_load = 32'h1;
    tick; tick;
    ren[1] = 1'b0;
    tick;
    vectors++;
    if (dut.r_rr_ptr !== 2'd2) begin
      errors++; $display("FAIL rstbusy_pre_ptr: got %0d want 2", dut.r_rr_ptr);
    end
    mem_complete = 1'b0; ren[2] = 1'b1; addr[2] = 32'h55;
    tick;
    vectors++;
    if (mem_REN !== 1'b1) begin
      errors++; $display("FAIL rstbusy_pre_ren: got %b want 1", mem_REN);
    end
    #2 rst = 1'b1;
    #1;
    all_out = {rdata, cpl, mem_REN, mem_WEN, mem_addr, mem_store, grant, busy};
    vectors++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rstbusy_outputs: got %h want 0", all_out);
    end
    vectors++;
    if ({dut.r_state, dut.r_rr_ptr} !== 4'b0000) begin
      errors++; $display("FAIL rstbusy_state_ptr: got state=%0d ptr=%0d want 0 0", dut.r_state, dut.r_rr_ptr);
    end
    ren[2] = 1'b0;
    tick;
    rst = 1'b0; mem_complete = 1'b1; mem_load = 32'hBAD;
    for (int c = 0; c < 3; c++) begin
      tick;
      vectors++;
      if ({cpl, busy, mem_REN} !== '0) begin
        errors++; $display("FAIL rstbusy_stray[%0d]: got cpl=%b busy=%b ren=%b want 0", c, cpl, busy, mem_REN);
      end
    end
    mem_complete = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ren = '0; wen = '0; addr = '0; store = '0;
    mem_load = '0; mem_complete = 1'b1;
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_ren_wen;
    test_change_withdraw;
    test_reset_busy;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
